// File: rtl/mrnaiso_pkg.sv
// Shared types for the mRNA isolation valve sequencer: state encoding, the
// 14-line valve vector (1 = pressurised = valve closed) and per-state open sets.
package mrnaiso_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_LYSE    = 4'd2,
        ST_BEAD    = 4'd3,
        ST_MIX     = 4'd4,
        ST_SEP     = 4'd5,
        ST_WASH    = 4'd6,
        ST_COLLECT = 4'd7,
        ST_DONE    = 4'd8,
        ST_ABORT   = 4'd9
    } state_e;

    typedef struct packed {
        logic cells_in;
        logic cells_out;
        logic collect;
        logic lysis_in;
        logic lysis_waste;
        logic beads_in;
        logic bead_waste;
        logic pump_1;
        logic pump_2;
        logic pump_3;
        logic push;
        logic sep;
        logic sieve;
        logic waste;
    } valve_t;

    localparam valve_t VALVES_CLOSED = '1;

    localparam valve_t V_LOAD    = '{cells_in: 1'b0, cells_out: 1'b0, waste: 1'b0, default: 1'b1};
    localparam valve_t V_LYSE    = '{lysis_in: 1'b0, lysis_waste: 1'b0, default: 1'b1};
    localparam valve_t V_BEAD    = '{beads_in: 1'b0, bead_waste: 1'b0, default: 1'b1};
    localparam valve_t V_SEP     = '{sep: 1'b0, sieve: 1'b0, default: 1'b1};
    localparam valve_t V_WASH    = '{push: 1'b0, waste: 1'b0, default: 1'b1};
    localparam valve_t V_COLLECT = '{push: 1'b0, collect: 1'b0, default: 1'b1};
    localparam valve_t V_ABORT   = '{waste: 1'b0, default: 1'b1};

    // Pump lines stay closed here; during MIX they come from the pump sub-block.
    function automatic valve_t valves_for(state_e s);
        case (s)
            ST_LOAD:    return V_LOAD;
            ST_LYSE:    return V_LYSE;
            ST_BEAD:    return V_BEAD;
            ST_SEP:     return V_SEP;
            ST_WASH:    return V_WASH;
            ST_COLLECT: return V_COLLECT;
            ST_ABORT:   return V_ABORT;
            default:    return VALVES_CLOSED;
        endcase
    endfunction

endpackage

// File: rtl/mrnaiso_peristaltic_pump.sv
// Three-valve peristaltic pump driver: one valve open at a time, PUMP_STEP
// cycles per step, flags the last cycle of MIX_ROT full rotations.
module mrnaiso_peristaltic_pump
    import mrnaiso_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PUMP_STEP = 8,
    parameter int MIX_ROT   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       load_i,
    input  logic       dir_i,
    output logic [2:0] pump_o,
    output logic       rot_done_o
);

    localparam longint LIMIT = longint'(1) << CNT_W;

    if (PUMP_STEP < 1 || longint'(PUMP_STEP - 1) >= LIMIT ||
        MIX_ROT < 1 || longint'(MIX_ROT - 1) >= LIMIT) begin : g_bad_pump_params
        $error("mrnaiso_peristaltic_pump: PUMP_STEP/MIX_ROT out of range for CNT_W");
    end

    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       pump_q, pump_d;
    logic             last_step;
    logic             last_idx;
    logic [1:0]       idx_next;

    // {p1,p2,p3}; every rotation starts with p1 open in either direction.
    function automatic logic [2:0] pattern(input logic dir, input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b011;
            2'd1:    return dir ? 3'b110 : 3'b101;
            2'd2:    return dir ? 3'b101 : 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    assign last_step  = (step_cnt_q == CNT_W'(PUMP_STEP - 1));
    assign last_idx   = (idx_q == 2'd2);
    assign idx_next   = last_idx ? 2'd0 : idx_q + 2'd1;
    assign rot_done_o = last_step && last_idx && (rot_cnt_q == CNT_W'(MIX_ROT - 1));
    assign pump_o     = pump_q;

    always_comb begin
        step_cnt_d = step_cnt_q;
        rot_cnt_d  = rot_cnt_q;
        idx_d      = idx_q;
        pump_d     = pump_q;
        if (!enable_i) begin
            step_cnt_d = '0;
            rot_cnt_d  = '0;
            idx_d      = 2'd0;
            pump_d     = 3'b111;
        end else if (load_i) begin
            step_cnt_d = '0;
            rot_cnt_d  = '0;
            idx_d      = 2'd0;
            pump_d     = pattern(dir_i, 2'd0);
        end else if (last_step) begin
            step_cnt_d = '0;
            idx_d      = idx_next;
            pump_d     = pattern(dir_i, idx_next);
            if (last_idx) begin
                rot_cnt_d = rot_cnt_q + CNT_W'(1);
            end
        end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            rot_cnt_q  <= '0;
            idx_q      <= 2'd0;
            pump_q     <= 3'b111;
        end else begin
            step_cnt_q <= step_cnt_d;
            rot_cnt_q  <= rot_cnt_d;
            idx_q      <= idx_d;
            pump_q     <= pump_d;
        end
    end

endmodule

// File: rtl/mrnaiso_valve_sequencer.sv
// Isolation-run sequencer: drives all 14 pneumatic lines through
// load, lyse, bead, mix, separate, wash, collect, with level-sensitive abort.
//
// state   | meaning
// IDLE    | all valves closed, waiting for start
// LOAD    | cells in/out and waste open, T_LOAD cycles
// LYSE    | lysis buffer flows, T_LYSE cycles
// BEAD    | bead line open, T_BEAD cycles
// MIX     | peristaltic pump, 3*PUMP_STEP*MIX_ROT cycles
// SEP     | sieve/separation hold, T_SEP cycles
// WASH    | push and waste open, T_WASH cycles
// COLLECT | push and collect open, T_COLLECT cycles
// DONE    | one-cycle completion pulse
// ABORT   | waste only, T_WASH cycles, then IDLE with err set
module mrnaiso_valve_sequencer
    import mrnaiso_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int T_LOAD    = 200,
    parameter int T_LYSE    = 400,
    parameter int T_BEAD    = 200,
    parameter int PUMP_STEP = 8,
    parameter int MIX_ROT   = 50,
    parameter int T_SEP     = 300,
    parameter int T_WASH    = 100,
    parameter int T_COLLECT = 150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pump_dir,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] phase,
    output logic       cells_in_ctl,
    output logic       cells_out_ctl,
    output logic       collect_ctl,
    output logic       lysis_in_ctl,
    output logic       lysis_waste_ctl,
    output logic       beads_in_ctl,
    output logic       bead_waste_ctl,
    output logic       pump_1,
    output logic       pump_2,
    output logic       pump_3,
    output logic       push_ctl,
    output logic       sep_ctl,
    output logic       sieve_ctl,
    output logic       waste_ctl
);

    localparam longint LIMIT = longint'(1) << CNT_W;

    function automatic bit t_ok(input int t);
        return (t >= 1) && (longint'(t - 1) < LIMIT);
    endfunction

    if (!(t_ok(T_LOAD) && t_ok(T_LYSE) && t_ok(T_BEAD) && t_ok(T_SEP) &&
          t_ok(T_WASH) && t_ok(T_COLLECT))) begin : g_bad_timer_params
        $error("mrnaiso_valve_sequencer: phase duration out of range for CNT_W");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    valve_t           valves_q, valves_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             dir_q, dir_d;
    logic             timer_zero;
    logic             active;
    logic [2:0]       pump_vec;
    logic             rot_done;

    function automatic logic [CNT_W-1:0] t_init(input int t);
        return CNT_W'(t - 1);
    endfunction

    assign timer_zero = (timer_q == '0);
    assign active     = state_q inside {ST_LOAD, ST_LYSE, ST_BEAD, ST_MIX,
                                        ST_SEP, ST_WASH, ST_COLLECT};

    mrnaiso_peristaltic_pump #(
        .CNT_W     (CNT_W),
        .PUMP_STEP (PUMP_STEP),
        .MIX_ROT   (MIX_ROT)
    ) u_pump (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (state_d == ST_MIX),
        .load_i     (state_q != ST_MIX),
        .dir_i      (dir_q),
        .pump_o     (pump_vec),
        .rot_done_o (rot_done)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_zero ? timer_q : timer_q - CNT_W'(1);
        err_d   = err_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    timer_d = t_init(T_LOAD);
                    err_d   = 1'b0;
                    dir_d   = pump_dir;
                end
            end
            ST_LOAD:    if (timer_zero) begin state_d = ST_LYSE;    timer_d = t_init(T_LYSE);    end
            ST_LYSE:    if (timer_zero) begin state_d = ST_BEAD;    timer_d = t_init(T_BEAD);    end
            ST_BEAD:    if (timer_zero) begin state_d = ST_MIX;                                  end
            ST_MIX:     if (rot_done)   begin state_d = ST_SEP;     timer_d = t_init(T_SEP);     end
            ST_SEP:     if (timer_zero) begin state_d = ST_WASH;    timer_d = t_init(T_WASH);    end
            ST_WASH:    if (timer_zero) begin state_d = ST_COLLECT; timer_d = t_init(T_COLLECT); end
            ST_COLLECT: if (timer_zero) begin state_d = ST_DONE;                                 end
            ST_DONE:    state_d = ST_IDLE;
            ST_ABORT: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        // Abort outranks any timed transition, including the last cycle of a phase.
        if (abort && active) begin
            state_d = ST_ABORT;
            timer_d = t_init(T_WASH);
        end
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        valves_d = valves_for(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            valves_q <= VALVES_CLOSED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            valves_q <= valves_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign phase           = state_q;
    assign cells_in_ctl    = valves_q.cells_in;
    assign cells_out_ctl   = valves_q.cells_out;
    assign collect_ctl     = valves_q.collect;
    assign lysis_in_ctl    = valves_q.lysis_in;
    assign lysis_waste_ctl = valves_q.lysis_waste;
    assign beads_in_ctl    = valves_q.beads_in;
    assign bead_waste_ctl  = valves_q.bead_waste;
    assign pump_1          = valves_q.pump_1 & pump_vec[2];
    assign pump_2          = valves_q.pump_2 & pump_vec[1];
    assign pump_3          = valves_q.pump_3 & pump_vec[0];
    assign push_ctl        = valves_q.push;
    assign sep_ctl         = valves_q.sep;
    assign sieve_ctl       = valves_q.sieve;
    assign waste_ctl       = valves_q.waste;

    a_reagent_interlock: assert property (@(posedge clk) disable iff (!rst_n)
        (lysis_in_ctl || beads_in_ctl));
    a_pump_interlock: assert property (@(posedge clk) disable iff (!rst_n)
        ($countones({pump_1, pump_2, pump_3}) >= 2));

endmodule

// File: tb/tb_mrnaiso_valve_sequencer.sv
// Bench for mrnaiso_valve_sequencer: a queue-based run-plan model predicts
// phase, valves and flags per cycle; scenario tasks compare against it.
module tb_mrnaiso_valve_sequencer;

    localparam int T_LOAD    = 4;
    localparam int T_LYSE    = 5;
    localparam int T_BEAD    = 3;
    localparam int PUMP_STEP = 2;
    localparam int MIX_ROT   = 2;
    localparam int T_SEP     = 3;
    localparam int T_WASH    = 2;
    localparam int T_COLLECT = 2;

    localparam logic [3:0] P_IDLE = 4'd0, P_LOAD = 4'd1, P_LYSE = 4'd2, P_BEAD = 4'd3,
                           P_MIX = 4'd4, P_SEP = 4'd5, P_WASH = 4'd6, P_COLLECT = 4'd7,
                           P_DONE = 4'd8, P_ABORT = 4'd9;
    localparam logic [13:0] ALL = 14'h3FFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, pump_dir = 1'b0;
    logic busy, done, err;
    logic [3:0] phase;
    logic cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl;
    logic beads_in_ctl, bead_waste_ctl, pump_1, pump_2, pump_3;
    logic push_ctl, sep_ctl, sieve_ctl, waste_ctl;

    always #5 clk = ~clk;

    mrnaiso_valve_sequencer #(
        .CNT_W(16), .T_LOAD(T_LOAD), .T_LYSE(T_LYSE), .T_BEAD(T_BEAD),
        .PUMP_STEP(PUMP_STEP), .MIX_ROT(MIX_ROT), .T_SEP(T_SEP),
        .T_WASH(T_WASH), .T_COLLECT(T_COLLECT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pump_dir(pump_dir),
        .busy(busy), .done(done), .err(err), .phase(phase),
        .cells_in_ctl(cells_in_ctl), .cells_out_ctl(cells_out_ctl), .collect_ctl(collect_ctl),
        .lysis_in_ctl(lysis_in_ctl), .lysis_waste_ctl(lysis_waste_ctl),
        .beads_in_ctl(beads_in_ctl), .bead_waste_ctl(bead_waste_ctl),
        .pump_1(pump_1), .pump_2(pump_2), .pump_3(pump_3),
        .push_ctl(push_ctl), .sep_ctl(sep_ctl), .sieve_ctl(sieve_ctl), .waste_ctl(waste_ctl)
    );

    // Bit order: cells_in, cells_out, collect, lysis_in, lysis_waste, beads_in,
    // bead_waste, p1, p2, p3, push, sep, sieve, waste (MSB first).
    wire [13:0] dut_v = {cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl,
                         lysis_waste_ctl, beads_in_ctl, bead_waste_ctl, pump_1, pump_2,
                         pump_3, push_ctl, sep_ctl, sieve_ctl, waste_ctl};
    wire [20:0] obs = {phase, dut_v, busy, done, err};

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  ph;
        logic [13:0] v;
    } entry_t;

    entry_t      cur;
    entry_t      plan[$];
    logic        m_err;
    logic [20:0] exp_v;

    function automatic logic [13:0] opened(input logic [13:0] m);
        return ALL & ~m;
    endfunction

    task automatic push_n(input logic [3:0] ph, input logic [13:0] v, input int n);
        repeat (n) plan.push_back({ph, v});
    endtask

    task automatic build_run(input logic dir);
        logic [2:0] pv;
        plan.delete();
        push_n(P_LOAD, opened(14'h2000 | 14'h1000 | 14'h0001), T_LOAD);
        push_n(P_LYSE, opened(14'h0400 | 14'h0200), T_LYSE);
        push_n(P_BEAD, opened(14'h0100 | 14'h0080), T_BEAD);
        for (int r = 0; r < MIX_ROT; r++) begin
            for (int s = 0; s < 3; s++) begin
                if (s == 0) pv = 3'b011;
                else pv = ((s == 1) ^ dir) ? 3'b101 : 3'b110;
                push_n(P_MIX, {7'h7F, pv, 4'hF}, PUMP_STEP);
            end
        end
        push_n(P_SEP, opened(14'h0004 | 14'h0002), T_SEP);
        push_n(P_WASH, opened(14'h0008 | 14'h0001), T_WASH);
        push_n(P_COLLECT, opened(14'h0008 | 14'h0800), T_COLLECT);
        push_n(P_DONE, ALL, 1);
    endtask

    task automatic model_reset();
        plan.delete();
        cur   = {P_IDLE, ALL};
        m_err = 1'b0;
        exp_v = {P_IDLE, ALL, 3'b000};
    endtask

    // Drive one cycle of inputs, clock, advance the model, settle past the edge.
    task automatic cycle(input logic s, input logic a, input logic d);
        start    = s;
        abort    = a;
        pump_dir = d;
        @(posedge clk);
        if (cur.ph == P_IDLE) begin
            if (s) begin
                build_run(d);
                m_err = 1'b0;
                cur   = plan.pop_front();
            end
        end else if (a && cur.ph != P_DONE && cur.ph != P_ABORT) begin
            plan.delete();
            push_n(P_ABORT, opened(14'h0001), T_WASH);
            cur = plan.pop_front();
        end else if (plan.size() == 0) begin
            if (cur.ph == P_ABORT) m_err = 1'b1;
            cur = {P_IDLE, ALL};
        end else begin
            cur = plan.pop_front();
        end
        exp_v = {cur.ph, cur.v, cur.ph != P_IDLE, cur.ph == P_DONE, m_err};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs !== {P_IDLE, ALL, 3'b000}) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, {P_IDLE, ALL, 3'b000});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mix_run(input logic dir);
        logic [2:0] fwd[12] = '{3'b011, 3'b011, 3'b101, 3'b101, 3'b110, 3'b110,
                                3'b011, 3'b011, 3'b101, 3'b101, 3'b110, 3'b110};
        logic [2:0] rev[12] = '{3'b011, 3'b011, 3'b110, 3'b110, 3'b101, 3'b101,
                                3'b011, 3'b011, 3'b110, 3'b110, 3'b101, 3'b101};
        logic [2:0] want;
        int load_cnt = 0, done_cnt = 0, done_at = 0, mix_cnt = 0;
        logic [3:0] after_mix = 4'hF;
        for (int i = 1; i <= 33; i++) begin
            cycle(i == 1, 1'b0, dir);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_trace dir=%0d cyc %0d got %h want %h", dir, i, obs, exp_v);
            end
            if (phase == P_LOAD && !cells_in_ctl && !cells_out_ctl && !waste_ctl) load_cnt++;
            if (done) begin done_cnt++; done_at = i; end
            if (phase == P_MIX) begin
                want = dir ? rev[mix_cnt % 12] : fwd[mix_cnt % 12];
                checks++;
                if ({pump_1, pump_2, pump_3} !== want) begin
                    errors++;
                    $display("FAIL mix_pumps dir=%0d step %0d got %b want %b",
                             dir, mix_cnt, {pump_1, pump_2, pump_3}, want);
                end
                mix_cnt++;
            end else if (mix_cnt > 0 && after_mix == 4'hF) begin
                after_mix = phase;
            end
        end
        checks++;
        if (load_cnt != T_LOAD) begin
            errors++;
            $display("FAIL load_len got %0d want 4", load_cnt);
        end
        checks++;
        if (mix_cnt != 12 || after_mix != P_SEP) begin
            errors++;
            $display("FAIL mix_len got %0d then phase %0d want 12 then 5", mix_cnt, after_mix);
        end
        checks++;
        if (done_cnt != 1 || done_at != 32) begin
            errors++;
            $display("FAIL done_pulse got count %0d at %0d want 1 at 32", done_cnt, done_at);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL run_err got %b want 0", err);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            // LOAD 1-4, LYSE 5-6; abort is high during the 2nd LYSE cycle
            cycle(i == 1, i == 7, 1'b0);
            if (done) done_cnt++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_trace cyc %0d got %h want %h", i, obs, exp_v);
            end
            if (i == 7 || i == 8) begin
                checks++;
                if (phase !== P_ABORT || dut_v !== 14'h3FFE) begin
                    errors++;
                    $display("FAIL abort_valves cyc %0d got ph %0d v %h want ph 9 v 3ffe",
                             i, phase, dut_v);
                end
            end
        end
        checks++;
        if (phase !== P_IDLE || err !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL abort_end got ph %0d err %b busy %b dones %0d want 0 1 0 0",
                     phase, err, busy, done_cnt);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || phase !== P_LOAD || obs !== exp_v) begin
            errors++;
            $display("FAIL err_clear got err %b ph %0d want err 0 ph 1", err, phase);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, i == 0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort_load_trace cyc %0d got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort_in_idle();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (phase !== P_IDLE || busy !== 1'b0 || obs !== exp_v) begin
                errors++;
                $display("FAIL idle_abort cyc %0d got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_start_abort_same_cycle();
        for (int i = 1; i <= 5; i++) begin
            cycle(i == 1, 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL start_abort_trace cyc %0d got %h want %h", i, obs, exp_v);
            end
            if (i <= 2) begin
                checks++;
                if (phase !== ((i == 1) ? P_LOAD : P_ABORT)) begin
                    errors++;
                    $display("FAIL start_abort_phase cyc %0d got %0d want %0d",
                             i, phase, (i == 1) ? P_LOAD : P_ABORT);
                end
            end
        end
    endtask

    task automatic test_start_held();
        int done_cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (done) done_cnt++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL held_trace cyc %0d got %h want %h", i, obs, exp_v);
            end
            if (i == 33 || i == 34) begin
                checks++;
                if (phase !== ((i == 33) ? P_IDLE : P_LOAD)) begin
                    errors++;
                    $display("FAIL held_restart cyc %0d got ph %0d want %0d",
                             i, phase, (i == 33) ? P_IDLE : P_LOAD);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL held_done_count got %0d want 1", done_cnt);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, i == 0, 1'b0);
        checks++;
        if (obs !== exp_v || phase !== P_IDLE) begin
            errors++;
            $display("FAIL held_cleanup got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_mix();
        for (int i = 1; i <= 15; i++) cycle(i == 1, 1'b0, 1'b1);
        checks++;
        if (phase !== P_MIX || obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_mix got %h want %h", obs, exp_v);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== ALL || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v %h busy %b want 3fff 0", dut_v, busy);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_v || phase !== P_IDLE) begin
            errors++;
            $display("FAIL post_reset got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_random_soak();
        logic s, a, d;
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 29) == 0);
            d = $urandom_range(0, 1);
            cycle(s, a, d);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL soak_trace cyc %0d got %h want %h", i, obs, exp_v);
            end
            checks++;
            if ((!lysis_in_ctl && !beads_in_ctl) ||
                ($countones({pump_1, pump_2, pump_3}) < 2)) begin
                errors++;
                $display("FAIL soak_interlock cyc %0d got v %h want interlock held", i, dut_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mix_run(1'b0);
        test_mix_run(1'b1);
        test_abort();
        test_abort_in_idle();
        test_start_abort_same_cycle();
        test_start_held();
        test_reset_mid_mix();
        test_random_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrnaiso_valve_sequencer.md
Name: mrnaiso_valve_sequencer

Overview:
- Control-side driver for the 4-lane mRNA isolation chip. It generates every pneumatic control line the fluidic netlist consumes, timed and ordered into one isolation run: load, lyse, bead capture, peristaltic mix, separate, wash, collect.
- Sits between the host/FPGA register interface and the solenoid driver board, one output bit per air line.
- Valve convention: output 1 means pressurised, which means the valve is closed.

Parameters:
- CNT_W, 16, width of phase timer and pump counters
- T_LOAD, 200, cycles cells_in/cells_out valves stay open
- T_LYSE, 400, cycles lysis buffer flows
- T_BEAD, 200, cycles bead line is open
- PUMP_STEP, 8, cycles per peristaltic step
- MIX_ROT, 50, full 3-step pump rotations in MIX
- T_SEP, 300, cycles sieve/separation hold
- T_WASH, 100, cycles waste flush
- T_COLLECT, 150, cycles collect path open

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a run; accepted only in IDLE
- abort  in  1  level; forces ABORT from any active state
- pump_dir  in  1  0 = forward (p1→p2→p3), 1 = reverse; sampled at start
- busy  out  1  high from accept until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky after abort; cleared by next accepted start
- phase  out  4  current state encoding (debug)
- cells_in_ctl, cells_out_ctl, collect_ctl  out  1 each  cell path valves
- lysis_in_ctl, lysis_waste_ctl  out  1 each  lysis buffer valves
- beads_in_ctl, bead_waste_ctl  out  1 each  bead line valves
- pump_1, pump_2, pump_3  out  1 each  peristaltic pump valves
- push_ctl, sep_ctl, sieve_ctl, waste_ctl  out  1 each  push/separation/waste valves

Behaviour:
Reset:
- All valve outputs are 1 (every valve closed).
- busy=0, done=0, err=0, phase=IDLE.
- Reset mid-run closes everything immediately (asynchronous), with no drain step.

States and transitions:
- IDLE→LOAD→LYSE→BEAD→MIX→SEP→WASH→COLLECT→DONE→IDLE.
- DONE lasts one cycle and asserts done.
- On entry to a timed state, the timer loads T−1. The state advances when the timer reaches 0, so each state lasts exactly T cycles. All T ≥ 1.
- MIX lasts exactly 3·PUMP_STEP·MIX_ROT cycles.

Outputs:
- All outputs are registered and change on the same edge the state changes.
- Output latency from start is 1 cycle: start sampled at edge k, so LOAD outputs and busy=1 appear after edge k.

Open valves per state (every valve not listed is 1):
- LOAD: cells_in_ctl, cells_out_ctl, waste_ctl.
- LYSE: lysis_in_ctl, lysis_waste_ctl.
- BEAD: beads_in_ctl, bead_waste_ctl.
- MIX: pumps only. With one open at a time, (p1,p2,p3) forward sequence is 011, 101, 110, repeating, and always starts at 011. Reverse sequence is 011, 110, 101. Each step holds PUMP_STEP cycles.
- SEP: sep_ctl, sieve_ctl.
- WASH: push_ctl, waste_ctl.
- COLLECT: push_ctl, collect_ctl.
- IDLE/DONE: none open.

Abort:
- abort=1 in any state other than IDLE/DONE/ABORT moves to ABORT on the next edge.
- ABORT: only waste_ctl is open, for T_WASH cycles, then IDLE with err=1 and no done pulse.
- abort in IDLE is ignored.
- abort and start in the same IDLE cycle: start wins, and abort is then seen in LOAD on the next cycle.
- start while busy is ignored (not queued).

Counters:
- Pump step counter and rotation counter are CNT_W wide and reset on MIX entry.
- No wrap within a phase; parameters must fit CNT_W (elaboration assertion).

Interlock invariant, checked by assertion:
- lysis_in_ctl and beads_in_ctl are never both 0.
- At most one pump valve is 0.

Decomposition:
- Package mrnaiso_pkg holds:
  - the state enum (IDLE, LOAD, LYSE, BEAD, MIX, SEP, WASH, COLLECT, DONE, ABORT) with its 4-bit encoding;
  - a valve-vector struct over the 14 air lines;
  - localparam VALVES_CLOSED (all ones);
  - the per-state open-valve constants.
- One sub-module, mrnaiso_peristaltic_pump: enable, dir, PUMP_STEP, MIX_ROT in; 3-bit pump vector and rot_done out. The main FSM instantiates it for MIX.

Test Plan:
- Use T_LOAD=4, T_LYSE=5, T_BEAD=3, PUMP_STEP=2, MIX_ROT=2, T_SEP=3, T_WASH=2, T_COLLECT=2.
- Reset asserted mid-MIX → all 14 valve outputs read 1 and busy=0 with no clock edge; after release, phase=IDLE.
- Start pulse in IDLE → busy rises 1 cycle later; LOAD shows cells_in/cells_out/waste at 0 for exactly 4 cycles; total run is 4+5+3+12+3+2+2 = 31 cycles, then a single done pulse; err stays 0.
- MIX forward → pump vector 011,011,101,101,110,110,011,011,101,101,110,110, then SEP. Rerun with pump_dir=1 → 011,011,110,110,101,101, repeated.
- abort raised on the 2nd LYSE cycle → next edge all closed except waste_ctl=0 for 2 cycles, then IDLE with err=1 and no done. A new start clears err.
- start held high through a whole run → no second run until after DONE. The cycle after DONE returns to IDLE; if start is still high, LOAD begins on the following edge.
- Random start/abort soak → interlock assertions never fire.
